// File: rtl/tlc_multi_approach_pkg.sv
// Shared types for the multi-approach traffic light controller.
// Light codes, FSM states and small constant helpers.
package tlc_pkg;

    localparam logic [1:0] LIGHT_DARK   = 2'b00;
    localparam logic [1:0] LIGHT_RED    = 2'b01;
    localparam logic [1:0] LIGHT_YELLOW = 2'b10;
    localparam logic [1:0] LIGHT_GREEN  = 2'b11;

    localparam logic [2:0] GREEN_IDX_NONE = 3'd7;

    typedef enum logic [3:0] {
        IDLE,
        MAIN_G,
        MAIN_EXT_G,
        MAIN_Y,
        SEC_G,
        SEC_Y,
        CLEAR_Y,
        FLASH,
        ALL_RED
    } state_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tlc_multi_approach_if.sv
// Road-side bundle: car counts and maintenance request in,
// light codes and green index out.
interface tlc_multi_approach_if #(
    parameter int N_APPR = 3
);
    import tlc_pkg::*;

    logic [8*N_APPR-1:0] cars;
    logic                flash_en;
    logic [2*N_APPR-1:0] ctl;
    logic [2:0]          green_idx;

    modport master (
        output cars,
        output flash_en,
        input  ctl,
        input  green_idx
    );

    modport slave (
        input  cars,
        input  flash_en,
        output ctl,
        output green_idx
    );

endinterface

// File: rtl/tlc_multi_approach_picker.sv
// Round-robin chooser over the secondary approaches.
// Skips approaches with no waiting cars.
module tlc_rr_picker
    import tlc_pkg::*;
#(
    parameter int N_APPR    = 3,
    parameter int THRESHOLD = 45
) (
    input  logic [8*N_APPR-1:0] i_cars,
    input  logic [2:0]          i_rr,
    output logic                o_found,
    output logic [2:0]          o_idx,
    output logic                o_above
);

    int w_pos;

    // Scan from the pointer, wrapping within 1..N_APPR-1; first hit wins.
    always_comb begin
        o_found = 1'b0;
        o_idx   = i_rr;
        o_above = 1'b0;
        w_pos   = 0;
        for (int k = 0; k < N_APPR - 1; k++) begin
            w_pos = int'(i_rr) + k;
            if (w_pos > N_APPR - 1) begin
                w_pos = w_pos - (N_APPR - 1);
            end
            if (!o_found && i_cars[8*w_pos +: 8] != 8'd0) begin
                o_found = 1'b1;
                o_idx   = 3'(w_pos);
                o_above = int'(i_cars[8*w_pos +: 8]) >= THRESHOLD;
            end
        end
    end

endmodule

// File: rtl/tlc_multi_approach.sv
// Multi-approach traffic light controller: main road plus
// round-robin secondaries, with flashing maintenance mode.
module tlc_multi_approach
    import tlc_pkg::*;
#(
    parameter int N_APPR     = 3,
    parameter int THRESHOLD  = 45,
    parameter int MAIN_GREEN = 30,
    parameter int MAIN_EXT   = 30,
    parameter int SEC_GREEN  = 10,
    parameter int YELLOW     = 3,
    parameter int FLASH_HALF = 8
) (
    input logic                 clk,
    input logic                 rst,
    tlc_multi_approach_if.slave bus
);

    localparam int T_MAX = max2(max2(max2(MAIN_GREEN, MAIN_EXT),
                                     max2(SEC_GREEN, YELLOW)),
                                FLASH_HALF);
    localparam int CW = $clog2(T_MAX) + 1;

    localparam logic [CW-1:0] L_MG = CW'(MAIN_GREEN - 1);
    localparam logic [CW-1:0] L_ME = CW'(MAIN_EXT - 1);
    localparam logic [CW-1:0] L_SG = CW'(SEC_GREEN - 1);
    localparam logic [CW-1:0] L_Y  = CW'(YELLOW - 1);
    localparam logic [CW-1:0] L_FH = CW'(FLASH_HALF - 1);

    state_t              r_state;
    state_t              w_state_nx;
    logic [CW-1:0]       r_cnt;
    logic [CW-1:0]       w_cnt_nx;
    logic [2:0]          r_rr;
    logic [2:0]          w_rr_nx;
    logic [2:0]          r_tgt;
    logic [2:0]          w_tgt_nx;
    logic [2:0]          r_clr;
    logic [2:0]          w_clr_nx;
    logic                r_fon;
    logic                w_fon_nx;
    logic                r_pend;
    logic                w_pend_nx;
    logic [2*N_APPR-1:0] r_ctl;
    logic [2*N_APPR-1:0] w_ctl_nx;
    logic [2:0]          r_gidx;
    logic [2:0]          w_gidx_nx;
    logic [1:0]          w_lt;
    logic                w_last;
    logic                w_found;
    logic                w_above;
    logic [2:0]          w_pick;
    logic [2:0]          w_rr_adv;

    tlc_rr_picker #(
        .N_APPR    (N_APPR),
        .THRESHOLD (THRESHOLD)
    ) u_picker (
        .i_cars  (bus.cars),
        .i_rr    (r_rr),
        .o_found (w_found),
        .o_idx   (w_pick),
        .o_above (w_above)
    );

    assign w_rr_adv = (r_tgt >= 3'(N_APPR - 1)) ? 3'd1 : r_tgt + 3'd1;

    // Last cycle of the current phase, per phase length.
    always_comb begin
        w_last = 1'b0;
        case (r_state)
            MAIN_G:     w_last = (r_cnt == L_MG);
            MAIN_EXT_G: w_last = (r_cnt == L_ME);
            SEC_G:      w_last = (r_cnt == L_SG);
            MAIN_Y,
            SEC_Y,
            CLEAR_Y,
            ALL_RED:    w_last = (r_cnt == L_Y);
            FLASH:      w_last = (r_cnt == L_FH);
            default:    w_last = 1'b0;
        endcase
    end

    // Next-state, counter and latched-context logic.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt + CW'(1);
        w_rr_nx    = r_rr;
        w_tgt_nx   = r_tgt;
        w_clr_nx   = r_clr;
        w_fon_nx   = r_fon;
        w_pend_nx  = r_pend;
        case (r_state)
            IDLE: begin
                w_state_nx = bus.flash_en ? FLASH : MAIN_G;
                w_fon_nx   = 1'b1;
            end
            MAIN_G: begin
                if (bus.flash_en) begin
                    w_state_nx = CLEAR_Y;
                    w_clr_nx   = 3'd0;
                end else if (w_last) begin
                    w_cnt_nx = '0;
                    if (w_found) begin
                        w_tgt_nx   = w_pick;
                        w_state_nx = w_above ? MAIN_Y : MAIN_EXT_G;
                    end
                end
            end
            MAIN_EXT_G: begin
                if (bus.flash_en) begin
                    w_state_nx = CLEAR_Y;
                    w_clr_nx   = 3'd0;
                end else if (w_last) begin
                    w_state_nx = MAIN_Y;
                end
            end
            MAIN_Y: begin
                w_pend_nx = r_pend | bus.flash_en;
                if (w_last) begin
                    w_pend_nx  = 1'b0;
                    w_fon_nx   = 1'b1;
                    w_state_nx = (r_pend | bus.flash_en) ? FLASH : SEC_G;
                end
            end
            SEC_G: begin
                if (bus.flash_en) begin
                    w_state_nx = CLEAR_Y;
                    w_clr_nx   = r_tgt;
                end else if (w_last) begin
                    w_state_nx = SEC_Y;
                end
            end
            SEC_Y: begin
                w_pend_nx = r_pend | bus.flash_en;
                if (w_last) begin
                    w_pend_nx  = 1'b0;
                    w_fon_nx   = 1'b1;
                    w_rr_nx    = w_rr_adv;
                    w_state_nx = (r_pend | bus.flash_en) ? FLASH : MAIN_G;
                end
            end
            CLEAR_Y: begin
                if (w_last) begin
                    w_state_nx = FLASH;
                    w_fon_nx   = 1'b1;
                end
            end
            FLASH: begin
                if (!bus.flash_en) begin
                    w_state_nx = ALL_RED;
                end else if (w_last) begin
                    w_cnt_nx = '0;
                    w_fon_nx = ~r_fon;
                end
            end
            ALL_RED: begin
                if (w_last) begin
                    w_state_nx = MAIN_G;
                end
            end
            default: begin
                w_state_nx = IDLE;
                w_cnt_nx   = '0;
            end
        endcase
        if (w_state_nx != r_state) begin
            w_cnt_nx = '0;
        end
    end

    // Decode the lights of the state being entered.
    always_comb begin
        w_ctl_nx  = '0;
        w_gidx_nx = GREEN_IDX_NONE;
        w_lt      = LIGHT_DARK;
        for (int i = 0; i < N_APPR; i++) begin
            case (w_state_nx)
                MAIN_G,
                MAIN_EXT_G: w_lt = (i == 0) ? LIGHT_GREEN : LIGHT_RED;
                MAIN_Y,
                SEC_Y:      w_lt = (i == 0 || 3'(i) == w_tgt_nx)
                                   ? LIGHT_YELLOW : LIGHT_RED;
                SEC_G:      w_lt = (3'(i) == w_tgt_nx)
                                   ? LIGHT_GREEN : LIGHT_RED;
                CLEAR_Y:    w_lt = (3'(i) == w_clr_nx)
                                   ? LIGHT_YELLOW : LIGHT_RED;
                FLASH:      w_lt = w_fon_nx ? LIGHT_YELLOW : LIGHT_DARK;
                ALL_RED:    w_lt = LIGHT_RED;
                default:    w_lt = LIGHT_DARK;
            endcase
            w_ctl_nx[2*i +: 2] = w_lt;
        end
        case (w_state_nx)
            MAIN_G,
            MAIN_EXT_G: w_gidx_nx = 3'd0;
            SEC_G:      w_gidx_nx = w_tgt_nx;
            default:    w_gidx_nx = GREEN_IDX_NONE;
        endcase
    end

    // State, counter and context registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_rr    <= 3'd1;
            r_tgt   <= 3'd1;
            r_clr   <= 3'd0;
            r_fon   <= 1'b1;
            r_pend  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_rr    <= w_rr_nx;
            r_tgt   <= w_tgt_nx;
            r_clr   <= w_clr_nx;
            r_fon   <= w_fon_nx;
            r_pend  <= w_pend_nx;
        end
    end

    // Registered lights so ctl always matches the current state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ctl  <= '0;
            r_gidx <= GREEN_IDX_NONE;
        end else begin
            r_ctl  <= w_ctl_nx;
            r_gidx <= w_gidx_nx;
        end
    end

    assign bus.ctl       = r_ctl;
    assign bus.green_idx = r_gidx;

endmodule
